// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-set controller: binary hh:mm:ss with a RUN / SET_HR / SET_MIN
// editing FSM, inactivity timeout, and blink/select flags for the display stage.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_pulse,
    input  logic       inc_pulse,
    input  logic       dec_pulse,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       set_hr,
    output logic       set_min,
    output logic       blink_on
);

    localparam int unsigned TO_W = (TIMEOUT_S == 0) ? 1 : $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      hours_q, hours_d;
    logic [5:0]      minutes_q, minutes_d;
    logic [5:0]      seconds_q, seconds_d;
    logic            blink_q, blink_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            do_inc;
    logic            do_dec;
    logic            to_expire;

    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        blink_d   = blink_q;
        to_cnt_d  = to_cnt_q;

        // inc and dec together cancel out but still count as activity
        do_inc    = inc_pulse & ~dec_pulse;
        do_dec    = dec_pulse & ~inc_pulse;

        to_expire = 1'b0;
        if (TIMEOUT_S != 0) begin
            to_expire = ((32'(to_cnt_q) + 32'd1) == TIMEOUT_S);
        end

        case (state_q)
            ST_RUN: begin
                blink_d  = 1'b0;
                to_cnt_d = '0;
                if (tick_1hz) begin
                    if (seconds_q == 6'd59) begin
                        seconds_d = 6'd0;
                        if (minutes_q == 6'd59) begin
                            minutes_d = 6'd0;
                            hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
                if (mode_pulse) begin
                    state_d = ST_SET_HR;
                    blink_d = 1'b1;
                end
            end

            ST_SET_HR, ST_SET_MIN: begin
                if (mode_pulse) begin
                    to_cnt_d = '0;
                    if (state_q == ST_SET_HR) begin
                        state_d = ST_SET_MIN;
                        blink_d = 1'b1;
                    end else begin
                        state_d   = ST_RUN;
                        seconds_d = 6'd0;
                        blink_d   = 1'b0;
                    end
                end else if (inc_pulse || dec_pulse) begin
                    to_cnt_d = '0;
                    blink_d  = 1'b1;
                    if (state_q == ST_SET_HR) begin
                        if (do_inc) begin
                            hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else if (do_dec) begin
                            hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
                        end
                    end else begin
                        if (do_inc) begin
                            minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                        end else if (do_dec) begin
                            minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
                        end
                    end
                end else if (tick_1hz) begin
                    if (to_expire) begin
                        state_d   = ST_RUN;
                        seconds_d = 6'd0;
                        blink_d   = 1'b0;
                        to_cnt_d  = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                        blink_d  = ~blink_q;
                    end
                end
            end

            default: begin
                state_d  = ST_RUN;
                blink_d  = 1'b0;
                to_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            hours_q   <= 5'd0;
            minutes_q <= 6'd0;
            seconds_q <= 6'd0;
            blink_q   <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            blink_q   <= blink_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign blink_on = blink_q;
    assign set_hr   = (state_q == ST_SET_HR);
    assign set_min  = (state_q == ST_SET_MIN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expected outputs are queued with each stimulus
// step and compared one cycle later.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       mode_pulse = 1'b0;
    logic       inc_pulse = 1'b0;
    logic       dec_pulse = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       set_hr;
    logic       set_min;
    logic       blink_on;

    always #5 clk = ~clk;

    clock_set_ctrl #(.TIMEOUT_S(30)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .mode_pulse (mode_pulse),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .set_hr     (set_hr),
        .set_min    (set_min),
        .blink_on   (blink_on)
    );

    typedef struct {
        string       tag;
        logic [19:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic expect_out(input string tag, input int h, input int m, input int s,
                              input bit shr, input bit smin, input bit blk);
        exp_t e;
        e.tag = tag;
        e.val = {5'(h), 6'(m), 6'(s), shr, smin, blk};
        sb.push_back(e);
    endtask

    task automatic go(input bit r, input bit t, input bit mo, input bit i, input bit d);
        rst        = r;
        tick_1hz   = t;
        mode_pulse = mo;
        inc_pulse  = i;
        dec_pulse  = d;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        tick_1hz   = 1'b0;
        mode_pulse = 1'b0;
        inc_pulse  = 1'b0;
        dec_pulse  = 1'b0;
    endtask

    task automatic check_out();
        exp_t        e;
        logic [19:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {hours, minutes, seconds, set_hr, set_min, blink_on};
            n_vec++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0d:%0d:%0d shr=%0b smin=%0b blk=%0b, expected %0d:%0d:%0d shr=%0b smin=%0b blk=%0b",
                       e.tag, hours, minutes, seconds, set_hr, set_min, blink_on,
                       e.val[19:15], e.val[14:9], e.val[8:3], e.val[2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic step(input string tag, input bit r, input bit t, input bit mo, input bit i,
                        input bit d, input int h, input int m, input int s,
                        input bit shr, input bit smin, input bit blk);
        expect_out(tag, h, m, s, shr, smin, blk);
        go(r, t, mo, i, d);
        check_out();
    endtask

    initial begin
        #1;
        go(1, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 3661 seconds of free running
        for (int k = 0; k < 3660; k++) go(0, 1, 0, 0, 0);
        step("run_3661", 0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);

        // edit to 23:59 with wrap in both directions
        step("enter_set_hr",  0, 0, 1, 0, 0,  1,  1, 1, 1, 0, 1);
        step("hr_dec",        0, 0, 0, 0, 1,  0,  1, 1, 1, 0, 1);
        step("hr_wrap_dn",    0, 0, 0, 0, 1, 23,  1, 1, 1, 0, 1);
        step("enter_set_min", 0, 0, 1, 0, 0, 23,  1, 1, 0, 1, 1);
        step("min_dec",       0, 0, 0, 0, 1, 23,  0, 1, 0, 1, 1);
        step("min_wrap_dn",   0, 0, 0, 0, 1, 23, 59, 1, 0, 1, 1);
        step("min_wrap_up",   0, 0, 0, 1, 0, 23,  0, 1, 0, 1, 1);
        step("min_dec2",      0, 0, 0, 0, 1, 23, 59, 1, 0, 1, 1);
        step("set_freeze",    0, 1, 0, 0, 0, 23, 59, 1, 0, 1, 0);
        step("exit_clr_sec",  0, 0, 1, 0, 0, 23, 59, 0, 0, 0, 0);
        for (int k = 0; k < 58; k++) go(0, 1, 0, 0, 0);
        step("sec_59",        0, 1, 0, 0, 0, 23, 59, 59, 0, 0, 0);
        step("midnight",      0, 1, 0, 0, 0,  0,  0, 0, 0, 0, 0);

        // hour wrap upward and same-cycle events in SET_HR
        step("enter_set_hr2", 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 1);
        step("hr_wrap_dn2",   0, 0, 0, 0, 1, 23, 0, 0, 1, 0, 1);
        step("hr_wrap_up",    0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 1);
        for (int k = 1; k <= 5; k++) step("hr_inc", 0, 0, 0, 1, 0, k, 0, 0, 1, 0, 1);
        step("hr_tick_blink", 0, 1, 0, 0, 0, 5, 0, 0, 1, 0, 0);
        step("inc_dec_same",  0, 0, 0, 1, 1, 5, 0, 0, 1, 0, 1);
        step("mode_inc_same", 0, 0, 1, 1, 0, 5, 0, 0, 0, 1, 1);
        step("exit_to_run",   0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0);

        // mode x3 from a running time clears seconds only
        for (int k = 0; k < 41; k++) go(0, 1, 0, 0, 0);
        step("sec_42",          0, 1, 0, 0, 0, 5, 0, 42, 0, 0, 0);
        step("mode_1",          0, 0, 1, 0, 0, 5, 0, 42, 1, 0, 1);
        step("mode_2",          0, 0, 1, 0, 0, 5, 0, 42, 0, 1, 1);
        step("mode_x3",         0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0);
        step("run_inc_ignored", 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0);
        step("run_dec_ignored", 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);

        // tick with mode in RUN, then timeout from SET_MIN
        step("tick_mode_run", 0, 1, 1, 0, 0, 5, 0, 1, 1, 0, 1);
        step("to_enter_min",  0, 0, 1, 0, 0, 5, 0, 1, 0, 1, 1);
        for (int k = 1; k <= 29; k++) step("to_blink", 0, 1, 0, 0, 0, 5, 0, 1, 0, 1, (k % 2) == 0);
        step("timeout", 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0);

        // timeout restarts from an edit on the 20th tick
        step("to2_set_hr",  0, 0, 1, 0, 0, 5, 0, 0, 1, 0, 1);
        step("to2_set_min", 0, 0, 1, 0, 0, 5, 0, 0, 0, 1, 1);
        for (int k = 0; k < 19; k++) go(0, 1, 0, 0, 0);
        step("tick_inc",    0, 1, 0, 1, 0, 5, 1, 0, 0, 1, 1);
        for (int k = 0; k < 28; k++) go(0, 1, 0, 0, 0);
        step("to2_tick29",  0, 1, 0, 0, 0, 5, 1, 0, 0, 1, 0);
        step("to2_timeout", 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0);

        // reset abandons an edit and beats a same-cycle inc
        step("rst_set_hr",  0, 0, 1, 0, 0, 5, 1, 0, 1, 0, 1);
        step("rst_inc_a",   0, 0, 0, 1, 0, 6, 1, 0, 1, 0, 1);
        step("rst_inc_b",   0, 0, 0, 1, 0, 7, 1, 0, 1, 0, 1);
        step("rst_in_set",  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Timekeeping and time-set controller for the digital clock. Consumes the single-cycle button pulses produced by the debounce/edge-detect front end (mode, increment, decrement) plus a 1 Hz tick. Maintains hours/minutes/seconds in binary, runs a three-state set-mode FSM with wrap-around editing and an inactivity timeout, and drives blink/select flags for the display stage.

## Interface
Parameters:
- TIMEOUT_S, 30, number of 1 Hz ticks without any button pulse after which a set mode returns to RUN; 0 disables the timeout
- Counter width for the timeout counter is derived internally as the minimum width that holds TIMEOUT_S; it is not a parameter

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- tick_1hz  input  1  one-cycle pulse once per second
- mode_pulse  input  1  one-cycle pulse, advances the set mode
- inc_pulse  input  1  one-cycle pulse, increments the selected field
- dec_pulse  input  1  one-cycle pulse, decrements the selected field
- hours  output  5  0..23, registered
- minutes  output  6  0..59, registered
- seconds  output  6  0..59, registered
- set_hr  output  1  high in SET_HR
- set_min  output  1  high in SET_MIN
- blink_on  output  1  display-visible phase of the selected field

## Operation
- FSM states: RUN, SET_HR, SET_MIN. A mode_pulse advances RUN->SET_HR->SET_MIN->RUN.
- RUN:
  - tick_1hz increments seconds.
  - At 59, seconds go to 0 and carry into minutes; minutes 59 go to 0 and carry into hours; hours 23 go to 0. 23:59:59 + tick = 00:00:00.
  - inc_pulse and dec_pulse are ignored.
- SET_HR and SET_MIN:
  - Timekeeping is frozen; tick_1hz does not advance time.
  - inc_pulse adds 1 to the selected field, dec_pulse subtracts 1. Hours wrap 23<->0 and minutes wrap 59<->0, with no carry into the other field.
- Any exit from a set mode to RUN, by mode_pulse or by timeout, clears seconds to 0. Hours and minutes keep their edited values.
- Timeout:
  - In set modes, each tick_1hz increments the timeout counter.
  - Any of mode/inc/dec high clears it to 0.
  - When the counter reaches TIMEOUT_S on a tick, the FSM goes to RUN (seconds cleared) and the counter clears.
  - With TIMEOUT_S=0 the counter never expires.
- blink_on:
  - 0 in RUN.
  - Set to 1 on entry to either set state and on every inc/dec pulse.
  - Otherwise toggles on each tick_1hz while in a set state.
- set_hr and set_min are decoded directly from the state register.
- Simultaneous events:
  - mode_pulse together with inc/dec: mode wins, inc/dec are dropped that cycle.
  - inc and dec together: field unchanged, but the timeout counter is still cleared and blink_on is still set to 1.
  - Tick together with inc/dec in a set mode: the edit applies, the timeout counter clears, and blink_on = 1.
  - Tick together with mode_pulse in RUN: the tick advances time and the state enters SET_HR in the same edge.
- An input held high is treated as one pulse per cycle; no edge detection is done here.

## Timing
- All outputs are registered and update on the clk edge at which the causing input is sampled high, so they are visible 1 cycle after the pulse.
- Reset is sampled on the clk edge. On reset: hours=0, minutes=0, seconds=0, state RUN (set_hr=0, set_min=0), blink_on=0, timeout counter=0.
- Reset during a set mode abandons the edit and returns to RUN at 00:00:00.
- Reset has priority over every other input in the same cycle.
- Throughput: one event per cycle. There are no handshakes and no stalls.

## Test plan
- Reset, then 3661 tick_1hz pulses in RUN -> hours=1, minutes=1, seconds=1. Set 23:59:59 via set mode, let one tick occur in RUN -> 00:00:00.
- From RUN: mode_pulse, then dec_pulse at hours=0 -> set_hr=1, hours=23. Then mode_pulse, then inc_pulse at minutes=59 -> set_min=1, minutes=0, hours still 23.
- From a running time with seconds=42: mode_pulse x3 -> back in RUN with seconds=0 and hours/minutes unchanged. inc_pulse in RUN leaves all fields unchanged.
- TIMEOUT_S=30:
  - Enter SET_MIN, give 29 ticks -> still SET_MIN, blink_on toggled 29 times from 1 (ends 0).
  - 1 more tick -> RUN, seconds=0.
  - Repeat with an inc_pulse at tick 20 -> timeout occurs only 30 ticks after the inc.
- Same-cycle events:
  - mode_pulse with inc_pulse in SET_HR -> SET_MIN, hours unchanged.
  - inc with dec in SET_HR at hours=5 -> hours=5, blink_on=1.
- rst asserted one cycle while in SET_HR with hours edited to 7 -> next cycle 00:00:00, RUN, blink_on=0. An inc_pulse in the same cycle as rst has no effect.
